// File: rtl/xeng_acc_capture_pkg.sv
`default_nettype none
// ============================================================================
// Package : xeng_pkg
// Brief   : Shared geometry helpers, FSM state encoding and the FIFO entry
//           layout for the X-engine accumulator capture sink.
// Rev     : 1.0  initial release
// ============================================================================
package xeng_pkg;

  // Width of one accumulated word leaving the last baseline tap.
  function automatic int calc_acc_width(input int bitwidth,
                                        input int p_factor_bits,
                                        input int serial_acc_len_bits);
    return 8 * (2 * bitwidth + 1 + p_factor_bits + serial_acc_len_bits);
  endfunction

  // Baselines (including autos) produced per window for dual-pol antennas.
  function automatic int calc_n_bls(input int n_ants);
    return (n_ants / 2 + 1) * n_ants;
  endfunction

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OVF  = 2'd2
  } state_t;

  // Entry geometry for the default build (N_ANTS=32, 16-bit windows).
  localparam int DEF_ACC_WIDTH = calc_acc_width(4, 2, 7);
  localparam int DEF_BL_BITS   = $clog2(calc_n_bls(32));
  localparam int DEF_WIN_BITS  = 16;

  typedef struct packed {
    logic [DEF_WIN_BITS-1:0]  win;
    logic [DEF_BL_BITS-1:0]   bl;
    logic                     last;
    logic [DEF_ACC_WIDTH-1:0] acc;
  } acc_entry_t;

endpackage
`default_nettype wire

// File: rtl/xeng_acc_capture_if.sv
`default_nettype none
// ============================================================================
// Interface : xeng_acc_capture_if
// Brief     : Tagged accumulation stream towards the packetiser (valid/ready).
// Rev       : 1.0  initial release
// ============================================================================
interface xeng_acc_capture_if #(
  parameter int ACC_WIDTH = 144,
  parameter int BL_BITS   = 10,
  parameter int WIN_BITS  = 16
);
  logic [ACC_WIDTH-1:0] m_data;
  logic [BL_BITS-1:0]   m_bl;
  logic [WIN_BITS-1:0]  m_win;
  logic                 m_last;
  logic                 m_valid;
  logic                 m_ready;

  modport master (
    output m_data, m_bl, m_win, m_last, m_valid,
    input  m_ready
  );

  modport slave (
    input  m_data, m_bl, m_win, m_last, m_valid,
    output m_ready
  );
endinterface
`default_nettype wire

// File: rtl/xeng_acc_fifo.sv
`default_nettype none
// ============================================================================
// Module : xeng_acc_fifo
// Brief  : Synchronous first-word-fall-through FIFO. The head word sits in a
//          registered output stage; total occupancy (storage + head) is
//          limited to 2**DEPTH_BITS words.
// Rev    : 1.0  initial release
// ============================================================================
module xeng_acc_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_BITS = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             empty
);
  localparam int DEPTH = 1 << DEPTH_BITS;
  localparam int CNT_W = DEPTH_BITS + 1;

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_BITS-1:0] wr_ptr;
  logic [DEPTH_BITS-1:0] rd_ptr;
  logic [CNT_W-1:0]      mem_cnt;
  logic                  head_valid;
  logic [CNT_W-1:0]      total;
  logic                  pop;
  logic                  push;
  logic                  load;

  assign total = mem_cnt + CNT_W'(head_valid);
  assign full  = (total == CNT_W'(DEPTH));
  assign empty = !head_valid;
  assign pop   = rd_en && head_valid;
  // A pop frees a slot in the same cycle, so a full FIFO still accepts.
  assign push  = wr_en && (!full || pop);
  // Refill the head stage whenever it is free or being consumed.
  assign load  = (!head_valid || pop) && (mem_cnt != '0);

  // Storage array write port; contents need no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers, occupancy and the registered head stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      mem_cnt    <= '0;
      head_valid <= 1'b0;
      dout       <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + DEPTH_BITS'(1);
      end
      if (load) begin
        rd_ptr     <= rd_ptr + DEPTH_BITS'(1);
        dout       <= mem[rd_ptr];
        head_valid <= 1'b1;
      end else if (pop) begin
        head_valid <= 1'b0;
      end
      mem_cnt <= mem_cnt + CNT_W'(push) - CNT_W'(load);
    end
  end
endmodule
`default_nettype wire

// File: rtl/xeng_acc_capture.sv
`default_nettype none
// ============================================================================
// Module : xeng_acc_capture
// Brief  : Sink for the X-engine accumulation chain. Tags each valid word with
//          its baseline index and window number, buffers it in a FWFT FIFO
//          and reports overflow, dropped words and short windows.
// Rev    : 1.0  initial release
// ============================================================================
module xeng_acc_capture
  import xeng_pkg::*;
#(
  parameter int SERIAL_ACC_LEN_BITS = 7,
  parameter int P_FACTOR_BITS       = 2,
  parameter int BITWIDTH            = 4,
  parameter int N_ANTS              = 32,
  parameter int FIFO_DEPTH_BITS     = 5,
  parameter int WIN_BITS            = 16,
  localparam int ACC_WIDTH = calc_acc_width(BITWIDTH, P_FACTOR_BITS, SERIAL_ACC_LEN_BITS),
  localparam int N_BLS     = calc_n_bls(N_ANTS),
  localparam int BL_BITS   = $clog2(N_BLS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sync_in,
  input  logic [ACC_WIDTH-1:0] acc_in,
  input  logic                 valid_in,
  xeng_acc_capture_if.master   m,
  output logic                 ovf,
  output logic [15:0]          drop_cnt,
  output logic                 short_win
);
  typedef struct packed {
    logic [WIN_BITS-1:0]  win;
    logic [BL_BITS-1:0]   bl;
    logic                 last;
    logic [ACC_WIDTH-1:0] acc;
  } entry_t;

  state_t              state;
  logic [BL_BITS-1:0]  bl_cnt;
  logic [WIN_BITS-1:0] win_cnt;

  // A sync applies to the word arriving in the same cycle, so every decision
  // is made on the "effective" state/counters after the sync is applied.
  state_t              eff_state;
  logic [BL_BITS-1:0]  eff_bl;
  logic [WIN_BITS-1:0] eff_win;
  logic                at_last;
  logic                fifo_full;
  logic                fifo_empty;
  logic                pop;
  logic                wr_en;
  logic                drop_run;
  logic                drop;
  entry_t              wr_entry;
  entry_t              rd_entry;

  // Effective context for this cycle and the accept/drop decision.
  always_comb begin
    eff_state = sync_in ? RUN : state;
    eff_bl    = sync_in ? '0 : bl_cnt;
    eff_win   = sync_in ? win_cnt + WIN_BITS'(1) : win_cnt;
    at_last   = (eff_bl == BL_BITS'(N_BLS - 1));
    pop       = m.m_ready && !fifo_empty;
    wr_en     = valid_in && (eff_state == RUN) && (!fifo_full || pop);
    drop_run  = valid_in && (eff_state == RUN) && fifo_full && !pop;
    drop      = drop_run || (valid_in && (eff_state == OVF));
    wr_entry.win  = eff_win;
    wr_entry.bl   = eff_bl;
    wr_entry.last = at_last;
    wr_entry.acc  = acc_in;
  end

  // Capture FSM, baseline/window counters and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      bl_cnt    <= '0;
      win_cnt   <= '1;
      ovf       <= 1'b0;
      drop_cnt  <= '0;
      short_win <= 1'b0;
    end else begin
      state   <= drop_run ? OVF : eff_state;
      win_cnt <= eff_win;
      if (wr_en) begin
        bl_cnt <= at_last ? '0 : eff_bl + BL_BITS'(1);
      end else begin
        bl_cnt <= eff_bl;
      end
      if (drop_run) begin
        ovf <= 1'b1;
      end else if (sync_in) begin
        ovf <= 1'b0;
      end
      if (drop && (drop_cnt != 16'hFFFF)) begin
        drop_cnt <= drop_cnt + 16'd1;
      end
      short_win <= sync_in && (state != IDLE) && (bl_cnt != '0);
    end
  end

  xeng_acc_fifo #(
    .WIDTH      ($bits(entry_t)),
    .DEPTH_BITS (FIFO_DEPTH_BITS)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .wr_en (wr_en),
    .din   (wr_entry),
    .full  (fifo_full),
    .rd_en (m.m_ready),
    .dout  (rd_entry),
    .empty (fifo_empty)
  );

  assign m.m_data  = rd_entry.acc;
  assign m.m_bl    = rd_entry.bl;
  assign m.m_win   = rd_entry.win;
  assign m.m_last  = rd_entry.last;
  assign m.m_valid = !fifo_empty;
endmodule
`default_nettype wire

// File: tb/tb_xeng_acc_capture.sv
`default_nettype none
// ============================================================================
// Module : tb_xeng_acc_capture
// Brief  : Randomised self-checking bench for xeng_acc_capture with a
//          queue-based reference model of the tagged output stream.
// Rev    : 1.0  initial release
// ============================================================================
module tb_xeng_acc_capture;
  localparam int SERIAL   = 7;
  localparam int PF       = 2;
  localparam int BW       = 4;
  localparam int N_ANTS   = 4;
  localparam int FDB      = 3;
  localparam int WIN_BITS = 16;
  localparam int ACC_WIDTH = 8 * (2 * BW + 1 + PF + SERIAL);
  localparam int N_BLS     = (N_ANTS / 2 + 1) * N_ANTS;
  localparam int BL_BITS   = $clog2(N_BLS);
  localparam int DEPTH     = 1 << FDB;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 sync_in = 1'b0;
  logic                 valid_in = 1'b0;
  logic [ACC_WIDTH-1:0] acc_in = '0;
  logic                 ovf;
  logic [15:0]          drop_cnt;
  logic                 short_win;

  xeng_acc_capture_if #(.ACC_WIDTH(ACC_WIDTH), .BL_BITS(BL_BITS), .WIN_BITS(WIN_BITS)) m_if ();

  xeng_acc_capture #(
    .SERIAL_ACC_LEN_BITS (SERIAL),
    .P_FACTOR_BITS       (PF),
    .BITWIDTH            (BW),
    .N_ANTS              (N_ANTS),
    .FIFO_DEPTH_BITS     (FDB),
    .WIN_BITS            (WIN_BITS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sync_in   (sync_in),
    .acc_in    (acc_in),
    .valid_in  (valid_in),
    .m         (m_if),
    .ovf       (ovf),
    .drop_cnt  (drop_cnt),
    .short_win (short_win)
  );

  always #5 clk = ~clk;

  // Reference model: words accepted but not yet handed over, in order.
  typedef struct {
    logic [ACC_WIDTH-1:0] acc;
    int                   bl;
    logic [15:0]          win;
    bit                   last;
    int                   wedge;
  } exp_t;

  exp_t        q[$];
  int          mode;      // 0 idle, 1 capturing, 2 discarding until sync
  int          bl;
  logic [15:0] win;
  bit          ovf_m;
  int          drops;
  bit          short_m;
  int          edge_n;
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    mode    = 0;
    bl      = 0;
    win     = 16'hFFFF;
    ovf_m   = 1'b0;
    drops   = 0;
    short_m = 1'b0;
    edge_n  = 0;
  endtask

  // A word written at edge N is visible from edge N+1 onwards.
  function automatic bit exp_valid();
    return (q.size() > 0) && (q[0].wedge < edge_n);
  endfunction

  function automatic logic [ACC_WIDTH-1:0] rand_acc();
    logic [159:0] r;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return r[ACC_WIDTH-1:0];
  endfunction

  task automatic compare_outputs();
    check("m_valid", m_if.m_valid, exp_valid());
    if (exp_valid()) begin
      check("m_data", m_if.m_data, q[0].acc);
      check("m_bl", m_if.m_bl, q[0].bl);
      check("m_win", m_if.m_win, q[0].win);
      check("m_last", m_if.m_last, q[0].last);
    end
    check("ovf", ovf, ovf_m);
    check("drop_cnt", drop_cnt, drops);
    check("short_win", short_win, short_m);
  endtask

  // One clock cycle: drive at the falling edge, check, then advance the model.
  task automatic step(input bit s, input bit v, input logic [ACC_WIDTH-1:0] a, input bit r);
    bit   pop;
    bit   full;
    exp_t e;
    @(negedge clk);
    sync_in     = s;
    valid_in    = v;
    acc_in      = a;
    m_if.m_ready = r;
    compare_outputs();
    pop  = r && exp_valid();
    full = (q.size() == DEPTH);
    @(posedge clk);
    edge_n++;
    if (pop) void'(q.pop_front());
    short_m = s && (mode != 0) && (bl != 0);
    if (s) begin
      mode  = 1;
      bl    = 0;
      win   = win + 16'd1;
      ovf_m = 1'b0;
    end
    if (v) begin
      if (mode == 1) begin
        if (!full || pop) begin
          e.acc   = a;
          e.bl    = bl;
          e.win   = win;
          e.last  = (bl == N_BLS - 1);
          e.wedge = edge_n;
          q.push_back(e);
          bl = (bl == N_BLS - 1) ? 0 : bl + 1;
        end else begin
          mode  = 2;
          ovf_m = 1'b1;
          if (drops < 65535) drops++;
        end
      end else if (mode == 2) begin
        if (drops < 65535) drops++;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n        = 1'b0;
    sync_in      = 1'b0;
    valid_in     = 1'b0;
    acc_in       = '0;
    m_if.m_ready = 1'b0;
    #1;
    check("rst_m_valid", m_if.m_valid, 0);
    check("rst_m_data", m_if.m_data, 0);
    check("rst_m_bl", m_if.m_bl, 0);
    check("rst_m_win", m_if.m_win, 0);
    check("rst_m_last", m_if.m_last, 0);
    check("rst_ovf", ovf, 0);
    check("rst_drop_cnt", drop_cnt, 0);
    check("rst_short_win", short_win, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, 1'b1);
  endtask

  initial begin
    model_reset();

    // Basic window: sync then one word per baseline, always ready.
    do_reset();
    step(1'b1, 1'b0, '0, 1'b1);
    for (int k = 0; k < N_BLS; k++) step(1'b0, 1'b1, ACC_WIDTH'(k), 1'b1);
    drain(4);

    // Words before any sync are ignored; sync with a word tags it bl 0 win 0.
    do_reset();
    for (int k = 0; k < 5; k++) step(1'b0, 1'b1, rand_acc(), 1'b1);
    step(1'b1, 1'b1, rand_acc(), 1'b1);
    drain(4);

    // Fill, write-with-pop at full, then overflow and recovery on sync.
    do_reset();
    step(1'b1, 1'b0, '0, 1'b0);
    for (int k = 0; k < DEPTH; k++) step(1'b0, 1'b1, rand_acc(), 1'b0);
    step(1'b0, 1'b1, rand_acc(), 1'b1);
    check("full_pop_no_drop", drop_cnt, 0);
    check("full_pop_no_ovf", ovf, 0);
    step(1'b0, 1'b1, rand_acc(), 1'b0);
    step(1'b0, 1'b1, rand_acc(), 1'b0);
    check("ovf_set", ovf, 1);
    check("ovf_drops", drop_cnt, 2);
    step(1'b1, 1'b0, '0, 1'b1);
    check("short_pulse", short_win, 1);
    check("ovf_cleared", ovf, 0);
    for (int k = 0; k < 4; k++) step(1'b0, 1'b1, rand_acc(), 1'b1);
    drain(DEPTH + 4);

    // Backpressure over three complete windows.
    do_reset();
    for (int w = 0; w < 3; w++) begin
      int sent;
      sent = 0;
      step(1'b1, 1'b0, '0, ($urandom_range(0, 3) != 0));
      while (sent < N_BLS) begin
        bit v;
        v = ($urandom_range(0, 1) == 1);
        step(1'b0, v, rand_acc(), ($urandom_range(0, 3) != 0));
        if (v) sent++;
      end
    end
    drain(DEPTH + 4);

    // Free-running random traffic with occasional syncs.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0),
           rand_acc(), ($urandom_range(0, 2) != 0));
    end
    drain(DEPTH + 4);

    // Reset in the middle of a window, then restart from window 0.
    do_reset();
    step(1'b1, 1'b0, '0, 1'b0);
    for (int k = 0; k < 6; k++) step(1'b0, 1'b1, rand_acc(), 1'b0);
    do_reset();
    step(1'b1, 1'b1, rand_acc(), 1'b1);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b1, rand_acc(), 1'b1);
    drain(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
